// File: rtl/uart_nco_pkg.sv
// Shared defaults and the increment calculator for the UART NCO baud generator.
// calc_inc rounds baud*os_rate*2^acc_w/f_clk to the nearest integer increment.
package uart_nco_pkg;

  localparam int          ACC_W_DEF       = 32;
  localparam int          OS_RATE_DEF     = 16;
  localparam logic [31:0] INC_DEFAULT_DEF = 32'd6597070;

  function automatic longint unsigned calc_inc(input longint unsigned f_clk,
                                               input longint unsigned baud,
                                               input longint unsigned os_rate,
                                               input int unsigned     acc_w);
    longint unsigned num;
    num = (baud * os_rate) << acc_w;
    return (num + (f_clk >> 1)) / f_clk;
  endfunction

endpackage

// File: rtl/uart_nco_baud_gen_if.sv
// Control/status bundle between a UART bit engine (master) and the NCO baud generator (slave).
// The resync strobe exists only when UART_NCO_RESYNC_EN is defined.
interface uart_nco_baud_gen_if
  import uart_nco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);

  logic             en;
  logic [ACC_W-1:0] inc_in;
  logic             inc_load;
`ifdef UART_NCO_RESYNC_EN
  logic             resync;
`endif
  logic             os_tick;
  logic             bit_tick;
  logic             nco_clk;
  logic [ACC_W-1:0] inc_active;
  logic             inc_pending;

`ifdef UART_NCO_RESYNC_EN
  modport master (output en, inc_in, inc_load, resync,
                  input  os_tick, bit_tick, nco_clk, inc_active, inc_pending);
  modport slave  (input  en, inc_in, inc_load, resync,
                  output os_tick, bit_tick, nco_clk, inc_active, inc_pending);
`else
  modport master (output en, inc_in, inc_load,
                  input  os_tick, bit_tick, nco_clk, inc_active, inc_pending);
  modport slave  (input  en, inc_in, inc_load,
                  output os_tick, bit_tick, nco_clk, inc_active, inc_pending);
`endif

endinterface

// File: rtl/uart_nco_phase_acc.sv
// Phase accumulator with shadowed increment; carry is combinational for the current edge.
// The shadow moves to the active increment only on an overflow, while idle, or while stalled at zero.
module uart_nco_phase_acc
  import uart_nco_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_DEFAULT_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_load,
  output logic             carry,
  output logic             acc_msb,
  output logic [ACC_W-1:0] inc_active,
  output logic             inc_pending
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] shadow_q;
  logic [ACC_W-1:0] active_q;
  logic             pending_q;
  logic [ACC_W:0]   sum;
  logic             xfer;

  assign sum   = {1'b0, acc_q} + {1'b0, active_q};
  assign carry = en & sum[ACC_W];
  // Swapping only at a period boundary keeps the tick train free of short periods.
  assign xfer  = pending_q & (carry | ~en | (active_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      shadow_q  <= INC_DEFAULT;
      active_q  <= INC_DEFAULT;
      pending_q <= 1'b0;
    end else begin
      if (clr) begin
        acc_q <= '0;
      end else if (en) begin
        acc_q <= sum[ACC_W-1:0];
      end
      if (inc_load) begin
        shadow_q <= inc_in;
      end
      if (xfer) begin
        active_q <= shadow_q;
      end
      if (inc_load) begin
        pending_q <= 1'b1;
      end else if (xfer) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign acc_msb     = acc_q[ACC_W-1];
  assign inc_active  = active_q;
  assign inc_pending = pending_q;

endmodule

// File: rtl/uart_nco_baud_gen.sv
// NCO baud generator: oversample tick per overflow, bit tick every OS_RATE overflows, NCO clock.
// Define UART_NCO_RESYNC_EN to add the resync strobe that restarts phase at mid-bit.
module uart_nco_baud_gen
  import uart_nco_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEF,
  parameter int               OS_RATE     = OS_RATE_DEF,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_DEFAULT_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_nco_baud_gen_if.slave  bus
);

  localparam int               CNT_W    = $clog2(OS_RATE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OS_RATE / 2);

  logic             carry;
  logic             acc_msb;
  logic             clr;
  logic [ACC_W-1:0] inc_active;
  logic             inc_pending;
  logic [CNT_W-1:0] os_cnt_q;
  logic             os_tick_q;
  logic             bit_tick_q;

`ifdef UART_NCO_RESYNC_EN
  assign clr = bus.resync;
`else
  assign clr = 1'b0;
`endif

  uart_nco_phase_acc #(
    .ACC_W       (ACC_W),
    .INC_DEFAULT (INC_DEFAULT)
  ) u_phase_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (bus.en),
    .clr         (clr),
    .inc_in      (bus.inc_in),
    .inc_load    (bus.inc_load),
    .carry       (carry),
    .acc_msb     (acc_msb),
    .inc_active  (inc_active),
    .inc_pending (inc_pending)
  );

  // Restarting at OS_RATE/2 puts the first bit tick half a bit after the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else if (clr) begin
      os_cnt_q   <= CNT_MID;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      os_tick_q  <= carry;
      bit_tick_q <= carry && (os_cnt_q == CNT_LAST);
      if (carry) begin
        os_cnt_q <= (os_cnt_q == CNT_LAST) ? '0 : os_cnt_q + 1'b1;
      end
    end
  end

  assign bus.os_tick     = os_tick_q;
  assign bus.bit_tick    = bit_tick_q;
  assign bus.nco_clk     = acc_msb;
  assign bus.inc_active  = inc_active;
  assign bus.inc_pending = inc_pending;

endmodule

// File: tb/tb_uart_nco_baud_gen.sv
// Scoreboarded bench for uart_nco_baud_gen: expected tick edges are queued as stimulus is applied
// and popped as the DUT emits ticks; register values are checked at chosen edges.
module tb_uart_nco_baud_gen;

  localparam logic [31:0] INC_DEF = 32'd6597070;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_os[$];
  int   exp_bit[$];
  int   last_os, gap, gap_min, gap_max, os_seen;
  int   base;

  uart_nco_baud_gen_if #(.ACC_W(32)) bus ();

  uart_nco_baud_gen #(
    .ACC_W       (32),
    .OS_RATE     (16),
    .INC_DEFAULT (INC_DEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // Tick monitor: every observed tick must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.os_tick) begin
        if (exp_os.size() == 0) check("os_tick_unexpected", 64'(edge_n), 64'd0);
        else                    check("os_tick_edge", 64'(edge_n), 64'(exp_os.pop_front()));
        if (last_os >= 0) begin
          gap = edge_n - last_os;
          if (gap < gap_min) gap_min = gap;
          if (gap > gap_max) gap_max = gap;
        end
        last_os = edge_n;
        os_seen++;
      end
      if (bus.bit_tick) begin
        if (exp_bit.size() == 0) check("bit_tick_unexpected", 64'(edge_n), 64'd0);
        else                     check("bit_tick_edge", 64'(edge_n), 64'(exp_bit.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.inc_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_idle(input logic [31:0] v);
    bus.en = 1'b0;
    bus.inc_in = v;
    bus.inc_load = 1'b1;
    @(negedge clk);
    bus.inc_load = 1'b0;
    @(negedge clk);
    check("load_idle_active", 64'(bus.inc_active), 64'(v));
    check("load_idle_pending", 64'(bus.inc_pending), 64'd0);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    check({tag, "_os_q_left"}, 64'(exp_os.size()), 64'd0);
    check({tag, "_bit_q_left"}, 64'(exp_bit.size()), 64'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.inc_in = '0;
    bus.inc_load = 1'b0;
`ifdef UART_NCO_RESYNC_EN
    bus.resync = 1'b0;
`endif
    last_os = -1; gap_min = 1 << 30; gap_max = 0; os_seen = 0;
    #12;
    check("rst_os_tick", 64'(bus.os_tick), 64'd0);
    check("rst_bit_tick", 64'(bus.bit_tick), 64'd0);
    check("rst_nco_clk", 64'(bus.nco_clk), 64'd0);
    check("rst_inc_active", 64'(bus.inc_active), 64'(INC_DEF));
    check("rst_inc_pending", 64'(bus.inc_pending), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Period 16 ticks, bit every 256 edges, NCO clock half period 8.
    load_idle(32'h1000_0000);
    base = edge_n;
    for (int j = 1; j <= 16; j++) exp_os.push_back(base + 16 * j);
    exp_bit.push_back(base + 256);
    bus.en = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (k <= 32) check("t1_nco_clk", 64'(bus.nco_clk), 64'((k % 16) >= 8));
    end
    bus.en = 1'b0;
    drain("t1");

    // Fractional rate: 6/256 ticks per edge over 1000 edges.
    do_reset();
    load_idle(32'h0600_0000);
    base = edge_n;
    for (int j = 1; j <= 23; j++) exp_os.push_back(base + (256 * j + 5) / 6);
    exp_bit.push_back(base + 683);
    last_os = -1; gap_min = 1 << 30; gap_max = 0; os_seen = 0;
    bus.en = 1'b1;
    repeat (1000) @(negedge clk);
    bus.en = 1'b0;
    drain("t2");
    check("t2_tick_count", 64'(os_seen), 64'd23);
    check("t2_gap_min", 64'(gap_min), 64'd42);
    check("t2_gap_max", 64'(gap_max), 64'd43);

    // Zero increment stalls; a load then transfers on the very next edge.
    do_reset();
    load_idle(32'h0000_0000);
    bus.en = 1'b1;
    repeat (20) @(negedge clk);
    check("zero_nco_static", 64'(bus.nco_clk), 64'd0);
    bus.inc_in = 32'h1000_0000;
    bus.inc_load = 1'b1;
    @(negedge clk);
    bus.inc_load = 1'b0;
    check("zero_pending", 64'(bus.inc_pending), 64'd1);
    check("zero_active_old", 64'(bus.inc_active), 64'd0);
    @(negedge clk);
    check("zero_active_new", 64'(bus.inc_active), 64'h1000_0000);
    check("zero_pending_clr", 64'(bus.inc_pending), 64'd0);
    base = edge_n;
    exp_os.push_back(base + 16);
    repeat (18) @(negedge clk);
    bus.en = 1'b0;
    drain("t_zero");

    // Idle: load coinciding with transfer keeps pending; newest value lands next.
    bus.inc_in = 32'h0111_0000;
    bus.inc_load = 1'b1;
    @(negedge clk);
    check("simul_pending_1", 64'(bus.inc_pending), 64'd1);
    bus.inc_in = 32'h0222_0000;
    @(negedge clk);
    bus.inc_load = 1'b0;
    check("simul_active_a", 64'(bus.inc_active), 64'h0111_0000);
    check("simul_pending_2", 64'(bus.inc_pending), 64'd1);
    @(negedge clk);
    check("simul_active_b", 64'(bus.inc_active), 64'h0222_0000);
    check("simul_pending_3", 64'(bus.inc_pending), 64'd0);

    // Increment change mid-period, then a 50-edge enable gap.
    do_reset();
    load_idle(32'h1000_0000);
    base = edge_n;
    exp_os.push_back(base + 16);  exp_os.push_back(base + 32);
    exp_os.push_back(base + 40);  exp_os.push_back(base + 48);
    exp_os.push_back(base + 56);  exp_os.push_back(base + 114);
    exp_os.push_back(base + 122);
    bus.en = 1'b1;
    for (int k = 1; k <= 126; k++) begin
      @(negedge clk);
      if (k == 20) begin bus.inc_in = 32'h3000_0000; bus.inc_load = 1'b1; end
      if (k == 21) bus.inc_in = 32'h2000_0000;
      if (k == 22) bus.inc_load = 1'b0;
      if (k == 31) begin
        check("chg_pending_hold", 64'(bus.inc_pending), 64'd1);
        check("chg_active_old", 64'(bus.inc_active), 64'h1000_0000);
      end
      if (k == 32) begin
        check("chg_pending_clr", 64'(bus.inc_pending), 64'd0);
        check("chg_active_new", 64'(bus.inc_active), 64'h2000_0000);
      end
      if (k == 60) bus.en = 1'b0;
      if (k == 61 || k == 110) check("hold_nco_clk", 64'(bus.nco_clk), 64'd1);
      if (k == 110) bus.en = 1'b1;
      if (k == 113) check("resume_nco_hi", 64'(bus.nco_clk), 64'd1);
      if (k == 114) check("resume_nco_lo", 64'(bus.nco_clk), 64'd0);
      if (k == 126) check("pre_rst_nco", 64'(bus.nco_clk), 64'd1);
    end
    bus.inc_in = 32'h5555_0000;
    bus.inc_load = 1'b1;
    @(negedge clk);
    bus.inc_load = 1'b0;
    check("pre_rst_pending", 64'(bus.inc_pending), 64'd1);
    check("t3_os_q_left", 64'(exp_os.size()), 64'd0);
    check("t3_bit_q_left", 64'(exp_bit.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst_inc_active", 64'(bus.inc_active), 64'(INC_DEF));
    check("arst_pending", 64'(bus.inc_pending), 64'd0);
    check("arst_nco_clk", 64'(bus.nco_clk), 64'd0);
    check("arst_os_tick", 64'(bus.os_tick), 64'd0);
    check("arst_bit_tick", 64'(bus.bit_tick), 64'd0);
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef UART_NCO_RESYNC_EN
    // Resync on an overflow edge: tick suppressed, bit tick 128 edges later.
    load_idle(32'h1000_0000);
    base = edge_n;
    exp_os.push_back(base + 16);
    for (int j = 0; j < 8; j++) exp_os.push_back(base + 48 + 16 * j);
    exp_bit.push_back(base + 160);
    bus.en = 1'b1;
    for (int k = 1; k <= 165; k++) begin
      @(negedge clk);
      if (k == 31) bus.resync = 1'b1;
      if (k == 32) begin
        bus.resync = 1'b0;
        check("resync_nco_clk", 64'(bus.nco_clk), 64'd0);
        check("resync_no_tick", 64'(bus.os_tick), 64'd0);
      end
    end
    bus.en = 1'b0;
    drain("resync");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
